// File: rtl/riscv_pkg.sv
// Shared RISC-V load/store definitions: funct3 width codes, LSU state
// encoding and small legality helpers used by the LSU and its lane aligner.
// Pure declarations; no logic or ports.
package riscv_pkg;

  // funct3 width codes for loads/stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2
  } lsu_state_t;

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b01:   return lo[0];
      2'b10:   return lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic load_f3_ok(input logic [2:0] f3);
    return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory request/response bus between the LSU (master) and memory (slave).
// Request side: dmem_req/we/addr/be/wdata held until dmem_gnt.
// Response side: dmem_rvalid qualifies dmem_rdata for one cycle.
interface load_store_unit_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Lane steering for the LSU: store byte enables + replicated store data,
// and load extraction (shift by byte offset, sign/zero extend). Purely combinational.
// Ports: st_* = store side (op being accepted), ld_* = load side (latched op + rdata).
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_data,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;

  // Replicating the data across lanes means memory just uses be to pick bytes.
  always_comb begin
    st_be   = 4'b1111;
    st_data = st_wdata;
    case (st_funct3[1:0])
      2'b00: begin
        st_be   = 4'b0001 << st_addr_lo;
        st_data = {4{st_wdata[7:0]}};
      end
      2'b01: begin
        st_be   = st_addr_lo[1] ? 4'b1100 : 4'b0011;
        st_data = {2{st_wdata[15:0]}};
      end
      default: begin
        st_be   = 4'b1111;
        st_data = st_wdata;
      end
    endcase
  end

  always_comb begin
    shifted = ld_rdata >> {ld_addr_lo, 3'b000};
    case (ld_funct3)
      F3_B:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   ld_data = {24'd0, shifted[7:0]};
      F3_HU:   ld_data = {16'd0, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory op from execute, issues it on dmem, writes back loads.
// Latency: load accept T -> req T+1 -> wb_valid T+3 at best; store accept T -> store_done T+2.
// Backpressure: ex_ready only in IDLE; dmem request held stable until dmem_gnt; TIMEOUT aborts with err.
// Ports: clk/rst_n; ex_* op inputs; dmem (master modport); wb_* load writeback; store_done/err pulses.
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ex_valid,
  output logic                      ex_ready,
  input  logic                      is_load,
  input  logic                      is_store,
  input  logic [2:0]                funct3,
  input  logic [31:0]               addr,
  input  logic [31:0]               wdata,
  input  logic [4:0]                rd,
  load_store_unit_if.master         dmem,
  output logic                      wb_valid,
  output logic [4:0]                wb_rd,
  output logic [31:0]               wb_data,
  output logic                      store_done,
  output logic                      err
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  // Abort on the edge where the counter would reach TIMEOUT.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  lsu_state_t  state;
  logic [CW-1:0] cnt;
  logic        op_store;
  logic [2:0]  op_funct3;
  logic [1:0]  op_addr_lo;
  logic [4:0]  op_rd;

  logic [3:0]  st_be;
  logic [31:0] st_data;
  logic [31:0] ld_data;
  logic        op_present;
  logic        illegal;

  assign ex_ready   = (state == LSU_IDLE);
  assign op_present = ex_valid & (is_load | is_store);
  assign illegal    = (is_load & is_store)
                    | (is_load & ~load_f3_ok(funct3))
                    | (is_store & funct3[2])
                    | f3_misaligned(funct3, addr[1:0]);

  lsu_align u_align (
    .st_funct3  (funct3),
    .st_addr_lo (addr[1:0]),
    .st_wdata   (wdata),
    .st_be      (st_be),
    .st_data    (st_data),
    .ld_funct3  (op_funct3),
    .ld_addr_lo (op_addr_lo),
    .ld_rdata   (dmem.dmem_rdata),
    .ld_data    (ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= LSU_IDLE;
      cnt             <= '0;
      op_store        <= 1'b0;
      op_funct3       <= 3'd0;
      op_addr_lo      <= 2'd0;
      op_rd           <= 5'd0;
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= 32'd0;
      dmem.dmem_be    <= 4'd0;
      dmem.dmem_wdata <= 32'd0;
      wb_valid        <= 1'b0;
      wb_rd           <= 5'd0;
      wb_data         <= 32'd0;
      store_done      <= 1'b0;
      err             <= 1'b0;
    end else begin
      // Pulse outputs default low every cycle.
      wb_valid   <= 1'b0;
      store_done <= 1'b0;
      err        <= 1'b0;

      case (state)
        LSU_IDLE: begin
          if (op_present) begin
            if (illegal) begin
              err <= 1'b1;
            end else begin
              op_store        <= is_store;
              op_funct3       <= funct3;
              op_addr_lo      <= addr[1:0];
              op_rd           <= rd;
              cnt             <= '0;
              dmem.dmem_req   <= 1'b1;
              dmem.dmem_we    <= is_store;
              dmem.dmem_addr  <= {addr[31:2], 2'b00};
              dmem.dmem_be    <= st_be;
              dmem.dmem_wdata <= st_data;
              state           <= LSU_REQ;
            end
          end
        end

        LSU_REQ: begin
          if (dmem.dmem_gnt) begin
            dmem.dmem_req <= 1'b0;
            dmem.dmem_we  <= 1'b0;
            cnt           <= '0;
            if (op_store) begin
              store_done <= 1'b1;
              state      <= LSU_IDLE;
            end else begin
              state <= LSU_WAIT;
            end
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              err           <= 1'b1;
              dmem.dmem_req <= 1'b0;
              dmem.dmem_we  <= 1'b0;
              state         <= LSU_IDLE;
            end
          end
        end

        LSU_WAIT: begin
          // rvalid only counts here, so a response in the grant cycle is dropped.
          if (dmem.dmem_rvalid) begin
            wb_valid <= 1'b1;
            wb_rd    <= op_rd;
            wb_data  <= ld_data;
            state    <= LSU_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              err   <= 1'b1;
              state <= LSU_IDLE;
            end
          end
        end

        default: state <= LSU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a vector table of single ops with immediate
// grant/response, plus hand sequences for held grant, timeout and reset in WAIT.
module tb_load_store_unit;
  import riscv_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        ex_valid_a, ex_valid_b;
  logic        ex_ready_a, ex_ready_b;
  logic        is_load, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic [4:0]  rd;
  logic        wb_valid_a, wb_valid_b;
  logic [4:0]  wb_rd_a, wb_rd_b;
  logic [31:0] wb_data_a, wb_data_b;
  logic        store_done_a, store_done_b;
  logic        err_a, err_b;

  load_store_unit_if dmem_a ();
  load_store_unit_if dmem_b ();

  load_store_unit u_dut_a (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid_a), .ex_ready(ex_ready_a),
    .is_load(is_load), .is_store(is_store), .funct3(funct3), .addr(addr),
    .wdata(wdata), .rd(rd), .dmem(dmem_a), .wb_valid(wb_valid_a), .wb_rd(wb_rd_a),
    .wb_data(wb_data_a), .store_done(store_done_a), .err(err_a)
  );

  load_store_unit #(.TIMEOUT(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid_b), .ex_ready(ex_ready_b),
    .is_load(is_load), .is_store(is_store), .funct3(funct3), .addr(addr),
    .wdata(wdata), .rd(rd), .dmem(dmem_b), .wb_valid(wb_valid_b), .wb_rd(wb_rd_b),
    .wb_data(wb_data_b), .store_done(store_done_b), .err(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rdat;
    logic [4:0]  r;
    logic        e_err;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs[16];

  task automatic drive_op(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input logic [4:0] r);
    is_load  = ld;
    is_store = st;
    funct3   = f3;
    addr     = a;
    wdata    = wd;
    rd       = r;
  endtask

  initial begin
    rst_n = 1'b0;
    ex_valid_a = 1'b0; ex_valid_b = 1'b0;
    drive_op(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
    dmem_a.dmem_gnt = 1'b0; dmem_a.dmem_rvalid = 1'b0; dmem_a.dmem_rdata = 32'd0;
    dmem_b.dmem_gnt = 1'b0; dmem_b.dmem_rvalid = 1'b0; dmem_b.dmem_rdata = 32'd0;

    //            ld   st   f3     addr          wdata         rdata         rd  err  be       dmem_wdata    wb_data
    vecs[0]  = '{1'b0,1'b1,F3_B, 32'h0000_1003,32'h0000_00A5,32'h0,        5'd0,1'b0,4'b1000,32'hA5A5A5A5,32'h0};
    vecs[1]  = '{1'b0,1'b1,F3_H, 32'h0000_1002,32'h1234_BEEF,32'h0,        5'd0,1'b0,4'b1100,32'hBEEFBEEF,32'h0};
    vecs[2]  = '{1'b0,1'b1,F3_W, 32'h0000_1004,32'hDEAD_BEEF,32'h0,        5'd0,1'b0,4'b1111,32'hDEADBEEF,32'h0};
    vecs[3]  = '{1'b0,1'b1,F3_B, 32'h0000_1000,32'h0000_0077,32'h0,        5'd0,1'b0,4'b0001,32'h77777777,32'h0};
    vecs[4]  = '{1'b1,1'b0,F3_B, 32'h0000_2002,32'h0,        32'h0080_0000,5'd3,1'b0,4'b0100,32'h0,       32'hFFFFFF80};
    vecs[5]  = '{1'b1,1'b0,F3_BU,32'h0000_2002,32'h0,        32'h0080_0000,5'd4,1'b0,4'b0100,32'h0,       32'h00000080};
    vecs[6]  = '{1'b1,1'b0,F3_H, 32'h0000_2002,32'h0,        32'h8001_0000,5'd5,1'b0,4'b1100,32'h0,       32'hFFFF8001};
    vecs[7]  = '{1'b1,1'b0,F3_HU,32'h0000_2000,32'h0,        32'h1234_F00D,5'd6,1'b0,4'b0011,32'h0,       32'h0000F00D};
    vecs[8]  = '{1'b1,1'b0,F3_W, 32'h0000_2004,32'h0,        32'hCAFE_F00D,5'd7,1'b0,4'b1111,32'h0,       32'hCAFEF00D};
    vecs[9]  = '{1'b1,1'b0,F3_B, 32'h0000_2001,32'h0,        32'h0000_7F00,5'd31,1'b0,4'b0010,32'h0,      32'h0000007F};
    vecs[10] = '{1'b1,1'b0,F3_W, 32'h0000_3002,32'h0,        32'h0,        5'd1,1'b1,4'b0000,32'h0,       32'h0};
    vecs[11] = '{1'b1,1'b0,F3_H, 32'h0000_3001,32'h0,        32'h0,        5'd1,1'b1,4'b0000,32'h0,       32'h0};
    vecs[12] = '{1'b0,1'b1,F3_W, 32'h0000_3001,32'h1,        32'h0,        5'd0,1'b1,4'b0000,32'h0,       32'h0};
    vecs[13] = '{1'b1,1'b0,3'b011,32'h0000_3000,32'h0,       32'h0,        5'd1,1'b1,4'b0000,32'h0,       32'h0};
    vecs[14] = '{1'b0,1'b1,F3_BU,32'h0000_3000,32'h5,        32'h0,        5'd0,1'b1,4'b0000,32'h0,       32'h0};
    vecs[15] = '{1'b1,1'b1,F3_W, 32'h0000_3000,32'h0,        32'h0,        5'd1,1'b1,4'b0000,32'h0,       32'h0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ex_ready", {31'd0, ex_ready_a}, 32'd1);
    chk("rst_req", {31'd0, dmem_a.dmem_req}, 32'd0);
    chk("rst_be", {28'd0, dmem_a.dmem_be}, 32'd0);
    chk("rst_err", {31'd0, err_a}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid_a}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Vector table: grant in first REQ cycle, rvalid in first WAIT cycle
    for (int i = 0; i < 16; i++) begin
      drive_op(vecs[i].ld, vecs[i].st, vecs[i].f3, vecs[i].a, vecs[i].wd, vecs[i].r);
      ex_valid_a = 1'b1;
      @(negedge clk);                         // accept edge T passed
      ex_valid_a = 1'b0;
      if (vecs[i].e_err) begin
        chk($sformatf("v%0d_err", i), {31'd0, err_a}, 32'd1);
        chk($sformatf("v%0d_noreq", i), {31'd0, dmem_a.dmem_req}, 32'd0);
        chk($sformatf("v%0d_ready", i), {31'd0, ex_ready_a}, 32'd1);
        @(negedge clk);
        chk($sformatf("v%0d_err_pulse", i), {31'd0, err_a}, 32'd0);
      end else begin
        chk($sformatf("v%0d_req", i), {31'd0, dmem_a.dmem_req}, 32'd1);
        chk($sformatf("v%0d_we", i), {31'd0, dmem_a.dmem_we}, {31'd0, vecs[i].st});
        chk($sformatf("v%0d_addr", i), dmem_a.dmem_addr, {vecs[i].a[31:2], 2'b00});
        chk($sformatf("v%0d_be", i), {28'd0, dmem_a.dmem_be}, {28'd0, vecs[i].e_be});
        chk($sformatf("v%0d_wdata", i), dmem_a.dmem_wdata, vecs[i].e_wd);
        chk($sformatf("v%0d_busy", i), {31'd0, ex_ready_a}, 32'd0);
        dmem_a.dmem_gnt = 1'b1;
        @(negedge clk);                       // edge T+2 passed
        dmem_a.dmem_gnt = 1'b0;
        chk($sformatf("v%0d_req_drop", i), {31'd0, dmem_a.dmem_req}, 32'd0);
        if (vecs[i].st) begin
          chk($sformatf("v%0d_store_done", i), {31'd0, store_done_a}, 32'd1);
          chk($sformatf("v%0d_idle", i), {31'd0, ex_ready_a}, 32'd1);
          @(negedge clk);
          chk($sformatf("v%0d_sd_pulse", i), {31'd0, store_done_a}, 32'd0);
        end else begin
          chk($sformatf("v%0d_no_sd", i), {31'd0, store_done_a}, 32'd0);
          dmem_a.dmem_rvalid = 1'b1;
          dmem_a.dmem_rdata  = vecs[i].rdat;
          @(negedge clk);                     // edge T+3 passed
          dmem_a.dmem_rvalid = 1'b0;
          chk($sformatf("v%0d_wb_valid", i), {31'd0, wb_valid_a}, 32'd1);
          chk($sformatf("v%0d_wb_data", i), wb_data_a, vecs[i].e_data);
          chk($sformatf("v%0d_wb_rd", i), {27'd0, wb_rd_a}, {27'd0, vecs[i].r});
          @(negedge clk);
          chk($sformatf("v%0d_wb_pulse", i), {31'd0, wb_valid_a}, 32'd0);
        end
      end
    end

    // LH with grant withheld 5 cycles; stray rvalid in REQ and in the grant cycle
    drive_op(1'b1, 1'b0, F3_H, 32'h0000_4002, 32'h0, 5'd9);
    ex_valid_a = 1'b1;
    @(negedge clk);
    ex_valid_a = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("hold%0d_req", k), {31'd0, dmem_a.dmem_req}, 32'd1);
      chk($sformatf("hold%0d_addr", k), dmem_a.dmem_addr, 32'h0000_4000);
      chk($sformatf("hold%0d_be", k), {28'd0, dmem_a.dmem_be}, 32'h0000_000C);
      dmem_a.dmem_rvalid = (k == 2) || (k == 5);
      dmem_a.dmem_rdata  = 32'hFFFF_0000;
      dmem_a.dmem_gnt    = (k == 5);
      @(negedge clk);
    end
    dmem_a.dmem_gnt = 1'b0;
    dmem_a.dmem_rvalid = 1'b0;
    chk("hold_req_drop", {31'd0, dmem_a.dmem_req}, 32'd0);
    chk("hold_ignore_gnt_rvalid", {31'd0, wb_valid_a}, 32'd0);
    chk("hold_wait_busy", {31'd0, ex_ready_a}, 32'd0);
    @(negedge clk);
    chk("hold_wait2", {31'd0, wb_valid_a}, 32'd0);
    @(negedge clk);
    dmem_a.dmem_rvalid = 1'b1;
    dmem_a.dmem_rdata  = 32'h7FFE_0000;
    @(negedge clk);
    dmem_a.dmem_rvalid = 1'b0;
    chk("hold_wb_valid", {31'd0, wb_valid_a}, 32'd1);
    chk("hold_wb_data", wb_data_a, 32'h0000_7FFE);
    chk("hold_wb_rd", {27'd0, wb_rd_a}, 32'd9);
    @(negedge clk);
    chk("hold_wb_pulse", {31'd0, wb_valid_a}, 32'd0);

    // Timeout on the TIMEOUT=4 instance: grant never arrives
    drive_op(1'b1, 1'b0, F3_W, 32'h0000_5000, 32'h0, 5'd2);
    ex_valid_b = 1'b1;
    @(negedge clk);
    ex_valid_b = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("to%0d_req", k), {31'd0, dmem_b.dmem_req}, 32'd1);
      chk($sformatf("to%0d_noerr", k), {31'd0, err_b}, 32'd0);
      @(negedge clk);
    end
    chk("to_err", {31'd0, err_b}, 32'd1);
    chk("to_req_drop", {31'd0, dmem_b.dmem_req}, 32'd0);
    chk("to_idle", {31'd0, ex_ready_b}, 32'd1);
    chk("to_no_wb", {31'd0, wb_valid_b}, 32'd0);
    @(negedge clk);
    chk("to_err_pulse", {31'd0, err_b}, 32'd0);
    drive_op(1'b0, 1'b1, F3_W, 32'h0000_5008, 32'h0BAD_F00D, 5'd0);
    ex_valid_b = 1'b1;
    @(negedge clk);
    ex_valid_b = 1'b0;
    chk("to_sw_req", {31'd0, dmem_b.dmem_req}, 32'd1);
    chk("to_sw_wdata", dmem_b.dmem_wdata, 32'h0BAD_F00D);
    dmem_b.dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_b.dmem_gnt = 1'b0;
    chk("to_sw_done", {31'd0, store_done_b}, 32'd1);

    // Reset pulsed while a load waits for its response
    drive_op(1'b1, 1'b0, F3_B, 32'h0000_6001, 32'h0, 5'd12);
    ex_valid_a = 1'b1;
    @(negedge clk);
    ex_valid_a = 1'b0;
    dmem_a.dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_a.dmem_gnt = 1'b0;
    chk("rw_in_wait", {31'd0, ex_ready_a}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rw_rst_ready", {31'd0, ex_ready_a}, 32'd1);
    chk("rw_rst_addr", dmem_a.dmem_addr, 32'd0);
    chk("rw_rst_be", {28'd0, dmem_a.dmem_be}, 32'd0);
    chk("rw_rst_wb_data", wb_data_a, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    dmem_a.dmem_rvalid = 1'b1;
    dmem_a.dmem_rdata  = 32'h0000_1100;
    @(negedge clk);
    dmem_a.dmem_rvalid = 1'b0;
    chk("rw_late_rvalid", {31'd0, wb_valid_a}, 32'd0);
    chk("rw_wb_rd", {27'd0, wb_rd_a}, 32'd0);
    chk("rw_req", {31'd0, dmem_a.dmem_req}, 32'd0);
    chk("rw_err", {31'd0, err_a}, 32'd0);
    chk("rw_ready", {31'd0, ex_ready_a}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the maximum cycles spent in REQ or WAIT before abort.
REQ-002 SHALL have clk  input  1  single clock; all state changes on the rising edge.
REQ-003 SHALL have rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ex_valid  input  1  execute stage presents a memory op.
REQ-005 SHALL have ex_ready  output  1  LSU can accept an op (state IDLE).
REQ-006 SHALL have is_load, is_store  input  1 each  op type; both high is illegal.
REQ-007 SHALL have funct3  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 SHALL have addr  input  32  effective address (ALU sum).
REQ-009 SHALL have wdata  input  32  store data (rs2).
REQ-010 SHALL have rd  input  5  load destination register.
REQ-011 SHALL have dmem_req, dmem_we  output  1 each  memory request and write enable.
REQ-012 SHALL have dmem_addr  output  32  word-aligned address {addr[31:2],2'b00}.
REQ-013 SHALL have dmem_be  output  4  byte enables; dmem_wdata  output  32  lane-aligned store data.
REQ-014 SHALL have dmem_gnt, dmem_rvalid  input  1 each; dmem_rdata  input  32.
REQ-015 SHALL have wb_valid  output  1; wb_rd  output  5; wb_data  output  32  load writeback.
REQ-016 SHALL have store_done, err  output  1 each  single-cycle pulses.

Function
REQ-017 SHALL implement states IDLE, REQ, WAIT; ex_ready = (state==IDLE), combinational.
REQ-018 In IDLE with ex_valid and exactly one of is_load/is_store set, SHALL latch addr, wdata, rd, funct3 and op type.
REQ-019 Misalignment (H/HU with addr[0]=1, W with addr[1:0]!=0), reserved funct3 (011, 110, 111) on a load, funct3[2]=1 on a store, or both op flags high SHALL pulse err the next cycle, issue no request, and remain in IDLE.
REQ-020 A legal op SHALL enter REQ the next cycle; dmem_req SHALL stay 1, with all dmem_* outputs stable, until dmem_gnt.
REQ-021 In REQ with dmem_gnt: a store SHALL return to IDLE and pulse store_done the following cycle; a load SHALL go to WAIT.
REQ-022 dmem_rvalid SHALL be ignored outside WAIT, including in the cycle of the grant.
REQ-023 In WAIT with dmem_rvalid, SHALL register wb_valid=1 for exactly one cycle, together with wb_rd and the extracted data, and return to IDLE.
REQ-024 Store lanes: B gives be=1<<addr[1:0] and data {4{wdata[7:0]}}; H gives be=addr[1]?1100:0011 and data {2{wdata[15:0]}}; W gives be=1111 and data wdata.
REQ-025 Load extract: shift rdata right by 8*addr[1:0]; B/H sign-extend bit 7/15; BU/HU zero-extend; W passes through.
REQ-026 Minimum latency with grant in the first REQ cycle and rvalid in the first WAIT cycle: load accept at T, req at T+1, wb_valid at T+3; store accept at T, store_done at T+2.
REQ-027 A cycle counter SHALL clear on entry to REQ and on the REQ-to-WAIT transition, and SHALL increment every cycle in REQ or WAIT.
REQ-028 When the counter reaches TIMEOUT, SHALL pulse err, drop dmem_req, and return to IDLE with no wb_valid or store_done.
REQ-029 dmem_we SHALL equal the latched is_store while dmem_req=1, and be 0 otherwise.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, clear the counter, and drive dmem_req, dmem_we, dmem_be, wb_valid, store_done and err to 0, and dmem_addr, dmem_wdata, wb_rd and wb_data to 0.
REQ-031 Reset during REQ or WAIT SHALL abandon the op; a late dmem_rvalid after reset release SHALL be ignored.

Structure
REQ-032 Shared package riscv_pkg SHALL hold the funct3 width-code constants and the lsu_state_t enum.
REQ-033 Lane alignment, byte-enable generation and load extension SHALL live in one combinational sub-module, lsu_align.

Verification
REQ-034 Store SB, addr=0x1003, wdata=0xA5, gnt in the first REQ cycle -> be=1000, dmem_addr=0x1000, dmem_wdata=0xA5A5A5A5, store_done 2 cycles after accept.
REQ-035 Load LB, addr=0x2002, rdata=0x00800000 -> wb_data=0xFFFFFF80; LBU with the same inputs -> 0x00000080; wb_valid exactly one cycle.
REQ-036 LW at addr=0x3002 -> err pulse, dmem_req never asserted, ex_ready stays 1.
REQ-037 LH with gnt withheld 5 cycles and rvalid 3 cycles after grant -> dmem_req held 6 cycles with stable addr/be; rvalid arriving in the grant cycle is ignored.
REQ-038 TIMEOUT=4, gnt never asserted -> err when the counter reaches 4 in REQ, then IDLE with dmem_req=0; a subsequent legal SW completes.
REQ-039 rst_n pulsed low in WAIT, rvalid arrives after release -> no wb_valid, all outputs 0, ex_ready=1.
